// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: the writeback-stage FIFO entry and its sizing limits.
package riscv_v_pkg;

  localparam int unsigned V_VLEN         = 128;
  localparam int unsigned V_XLEN         = 32;
  localparam int unsigned V_WB_DEPTH_MAX = 4;

  // One execute result beat as held in the writeback FIFO.
  typedef struct packed {
    logic                  is_v2i;
    logic [4:0]            vd;
    logic [4:0]            rd;
    logic [V_VLEN-1:0]     data;
    logic [V_VLEN/8-1:0]   byte_en;
    logic [V_XLEN-1:0]     int_data;
  } v_wb_entry_t;

endpackage

// File: rtl/riscv_v_wb_fifo.sv
// In-order FIFO of writeback entries; the head is read straight from storage.
module riscv_v_wb_fifo
  import riscv_v_pkg::*;
#(
  parameter int unsigned DEPTH = 2  // 2..V_WB_DEPTH_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  v_wb_entry_t entry,
  output v_wb_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  v_wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the cleared count keeps stale
  // contents invisible, and omitting reset lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

endmodule

// File: rtl/riscv_v_exe_wb_stage.sv
// Vector writeback stage: buffers execute beats, drains them in order to the
// VRF or scalar write port, and tracks pending vreg writes for hazard checks.
module riscv_v_exe_wb_stage
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN     = V_VLEN,
  parameter int unsigned XLEN     = V_XLEN,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned VREG_NUM = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_exe,
  output logic                ready_exe,
  input  logic                is_v2i_exe,
  input  logic [4:0]          vd_exe,
  input  logic [4:0]          rd_exe,
  input  logic [VLEN-1:0]     result_exe,
  input  logic [VLEN/8-1:0]   byte_en_exe,
  input  logic [XLEN-1:0]     int_result_exe,
  output logic                vrf_wr_en_wb,
  input  logic                vrf_wr_ready_wb,
  output logic [4:0]          vrf_wr_addr_wb,
  output logic [VLEN-1:0]     vrf_wr_data_wb,
  output logic [VLEN/8-1:0]   vrf_wr_be_wb,
  output logic                int_wr_valid_wb,
  input  logic                int_wr_ready_wb,
  output logic [4:0]          int_wr_addr_wb,
  output logic [XLEN-1:0]     int_wr_data_wb,
  output logic [VREG_NUM-1:0] vreg_busy_wb
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  v_wb_entry_t      in_entry;
  v_wb_entry_t      head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_vec;
  logic             head_vrf_write;
  logic [CNT_W-1:0] cnt      [VREG_NUM];
  logic [CNT_W-1:0] cnt_next [VREG_NUM];

  always_comb begin
    in_entry          = '0;
    in_entry.is_v2i   = is_v2i_exe;
    in_entry.vd       = vd_exe;
    in_entry.rd       = rd_exe;
    in_entry.data     = result_exe;
    in_entry.byte_en  = byte_en_exe;
    in_entry.int_data = int_result_exe;
  end

  // ready comes only from the stored count, so a full FIFO never accepts even
  // when its head drains in the same cycle.
  assign ready_exe = !full;
  assign push      = valid_exe && !full;

  riscv_v_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .entry (in_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_vec       = !empty && !head.is_v2i;
  assign head_vrf_write = head_vec && (head.byte_en != '0);

  // A fully masked vector beat has nothing to write and retires unconditionally.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (head.is_v2i)            pop = int_wr_ready_wb;
      else if (head.byte_en == '0) pop = 1'b1;
      else                        pop = vrf_wr_ready_wb;
    end
  end

  // NOTE: every output gets a default before the conditional so no latch is
  // inferred and idle ports read as zero.
  always_comb begin
    vrf_wr_en_wb    = 1'b0;
    vrf_wr_addr_wb  = '0;
    vrf_wr_data_wb  = '0;
    vrf_wr_be_wb    = '0;
    int_wr_valid_wb = 1'b0;
    int_wr_addr_wb  = '0;
    int_wr_data_wb  = '0;
    if (head_vrf_write) begin
      vrf_wr_en_wb   = 1'b1;
      vrf_wr_addr_wb = head.vd;
      vrf_wr_data_wb = head.data;
      vrf_wr_be_wb   = head.byte_en;
    end else if (!empty && head.is_v2i) begin
      int_wr_valid_wb = 1'b1;
      int_wr_addr_wb  = head.rd;
      int_wr_data_wb  = head.int_data;
    end
  end

  always_comb begin
    for (int r = 0; r < VREG_NUM; r++) begin
      cnt_next[r] = cnt[r];
      case ({push && !is_v2i_exe && (vd_exe == 5'(r)),
             pop && head_vec && (head.vd == 5'(r))})
        2'b10:   cnt_next[r] = cnt[r] + 1'b1;
        2'b01:   cnt_next[r] = cnt[r] - 1'b1;
        default: cnt_next[r] = cnt[r];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < VREG_NUM; r++) cnt[r] <= '0;
      vreg_busy_wb <= '0;
    end else begin
      for (int r = 0; r < VREG_NUM; r++) begin
        cnt[r]          <= cnt_next[r];
        vreg_busy_wb[r] <= (cnt_next[r] != '0);
      end
    end
  end

endmodule

// File: tb/tb_riscv_v_exe_wb_stage.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_riscv_v_exe_wb_stage;
  import riscv_v_pkg::*;

  localparam int unsigned VLEN     = 128;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned VREG_NUM = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_exe;
  logic                ready_exe;
  logic                is_v2i_exe;
  logic [4:0]          vd_exe;
  logic [4:0]          rd_exe;
  logic [VLEN-1:0]     result_exe;
  logic [VLEN/8-1:0]   byte_en_exe;
  logic [XLEN-1:0]     int_result_exe;
  logic                vrf_wr_en_wb;
  logic                vrf_wr_ready_wb;
  logic [4:0]          vrf_wr_addr_wb;
  logic [VLEN-1:0]     vrf_wr_data_wb;
  logic [VLEN/8-1:0]   vrf_wr_be_wb;
  logic                int_wr_valid_wb;
  logic                int_wr_ready_wb;
  logic [4:0]          int_wr_addr_wb;
  logic [XLEN-1:0]     int_wr_data_wb;
  logic [VREG_NUM-1:0] vreg_busy_wb;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  riscv_v_exe_wb_stage #(
    .VLEN(VLEN), .XLEN(XLEN), .DEPTH(DEPTH), .VREG_NUM(VREG_NUM)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_exe       (valid_exe),
    .ready_exe       (ready_exe),
    .is_v2i_exe      (is_v2i_exe),
    .vd_exe          (vd_exe),
    .rd_exe          (rd_exe),
    .result_exe      (result_exe),
    .byte_en_exe     (byte_en_exe),
    .int_result_exe  (int_result_exe),
    .vrf_wr_en_wb    (vrf_wr_en_wb),
    .vrf_wr_ready_wb (vrf_wr_ready_wb),
    .vrf_wr_addr_wb  (vrf_wr_addr_wb),
    .vrf_wr_data_wb  (vrf_wr_data_wb),
    .vrf_wr_be_wb    (vrf_wr_be_wb),
    .int_wr_valid_wb (int_wr_valid_wb),
    .int_wr_ready_wb (int_wr_ready_wb),
    .int_wr_addr_wb  (int_wr_addr_wb),
    .int_wr_data_wb  (int_wr_data_wb),
    .vreg_busy_wb    (vreg_busy_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a bounded in-order queue of beats.
  v_wb_entry_t q[$];
  v_wb_entry_t m_head;
  v_wb_entry_t m_new;
  bit          m_full;
  bit          m_pop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      m_full = (q.size() == DEPTH);
      m_pop  = 1'b0;
      if (q.size() > 0) begin
        m_head = q[0];
        if (m_head.is_v2i)             m_pop = int_wr_ready_wb;
        else if (m_head.byte_en == '0) m_pop = 1'b1;
        else                           m_pop = vrf_wr_ready_wb;
      end
      if (m_pop) void'(q.pop_front());
      if (valid_exe && !m_full) begin
        m_new          = '0;
        m_new.is_v2i   = is_v2i_exe;
        m_new.vd       = vd_exe;
        m_new.rd       = rd_exe;
        m_new.data     = result_exe;
        m_new.byte_en  = byte_en_exe;
        m_new.int_data = int_result_exe;
        q.push_back(m_new);
      end
    end
  end

  logic                e_vrf_en, e_int_valid, e_ready;
  logic [4:0]          e_vrf_addr, e_int_addr;
  logic [VLEN-1:0]     e_vrf_data;
  logic [VLEN/8-1:0]   e_vrf_be;
  logic [XLEN-1:0]     e_int_data;
  logic [VREG_NUM-1:0] e_busy;

  always @(negedge clk) begin
    if (armed) begin
      e_vrf_en = 0; e_vrf_addr = 0; e_vrf_data = 0; e_vrf_be = 0;
      e_int_valid = 0; e_int_addr = 0; e_int_data = 0;
      e_ready = (q.size() != DEPTH);
      e_busy = '0;
      foreach (q[i]) if (!q[i].is_v2i) e_busy[q[i].vd] = 1'b1;
      if (q.size() > 0) begin
        if (q[0].is_v2i) begin
          e_int_valid = 1; e_int_addr = q[0].rd; e_int_data = q[0].int_data;
        end else if (q[0].byte_en != '0) begin
          e_vrf_en = 1; e_vrf_addr = q[0].vd; e_vrf_data = q[0].data; e_vrf_be = q[0].byte_en;
        end
      end
      check("m_ready",     ready_exe,       e_ready);
      check("m_vrf_en",    vrf_wr_en_wb,    e_vrf_en);
      check("m_vrf_addr",  vrf_wr_addr_wb,  e_vrf_addr);
      check("m_vrf_data",  vrf_wr_data_wb,  e_vrf_data);
      check("m_vrf_be",    vrf_wr_be_wb,    e_vrf_be);
      check("m_int_valid", int_wr_valid_wb, e_int_valid);
      check("m_int_addr",  int_wr_addr_wb,  e_int_addr);
      check("m_int_data",  int_wr_data_wb,  e_int_data);
      check("m_busy",      vreg_busy_wb,    e_busy);
    end
  end

  task automatic set_vec(input logic [4:0] vd, input logic [VLEN-1:0] d, input logic [VLEN/8-1:0] be);
    valid_exe = 1; is_v2i_exe = 0; vd_exe = vd; rd_exe = 0;
    result_exe = d; byte_en_exe = be; int_result_exe = 0;
  endtask

  initial begin
    rst = 1; valid_exe = 0; is_v2i_exe = 0; vd_exe = 0; rd_exe = 0;
    result_exe = 0; byte_en_exe = 0; int_result_exe = 0;
    vrf_wr_ready_wb = 0; int_wr_ready_wb = 0;
    step();
    armed = 1;
    step();
    check("rst_ready", ready_exe, 1);
    check("rst_vrf_en", vrf_wr_en_wb, 0);
    check("rst_busy", vreg_busy_wb, 0);
    rst = 0;
    step();

    // Single vector beat to v3.
    vrf_wr_ready_wb = 1;
    set_vec(5'd3, 128'h1111_2222_3333_4444_5555_6666_7777_8888, '1);
    step();
    valid_exe = 0;
    check("s1_en", vrf_wr_en_wb, 1);
    check("s1_addr", vrf_wr_addr_wb, 3);
    check("s1_busy3", vreg_busy_wb[3], 1);
    step();
    check("s1_en_off", vrf_wr_en_wb, 0);
    check("s1_busy3_off", vreg_busy_wb[3], 0);

    // v2i beat held for 4 cycles by int_wr_ready.
    int_wr_ready_wb = 0;
    valid_exe = 1; is_v2i_exe = 1; rd_exe = 5'd7; int_result_exe = 32'hDEAD_BEEF;
    vd_exe = 5'd20; byte_en_exe = '1;
    step();
    valid_exe = 0; is_v2i_exe = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) int_wr_ready_wb = 1;
      check("s2_valid", int_wr_valid_wb, 1);
      check("s2_addr", int_wr_addr_wb, 7);
      check("s2_data", int_wr_data_wb, 32'hDEAD_BEEF);
      check("s2_ready", ready_exe, 1);
      check("s2_no_busy", vreg_busy_wb, 0);
      step();
    end
    int_wr_ready_wb = 0;
    check("s2_valid_off", int_wr_valid_wb, 0);

    // Three back-to-back beats against a stalled VRF port.
    vrf_wr_ready_wb = 0;
    set_vec(5'd10, 128'hA, '1);
    step();
    set_vec(5'd11, 128'hB, '1);
    step();
    set_vec(5'd12, 128'hC, '1);
    check("s3_full", ready_exe, 0);
    step();
    check("s3_full_hold", ready_exe, 0);
    check("s3_head_a", vrf_wr_addr_wb, 10);
    vrf_wr_ready_wb = 1;
    step();
    check("s3_ready_back", ready_exe, 1);
    check("s3_head_b", vrf_wr_addr_wb, 11);
    step();
    valid_exe = 0;
    check("s3_head_c", vrf_wr_addr_wb, 12);
    check("s3_data_c", vrf_wr_data_wb, 128'hC);
    step();
    check("s3_drained", vrf_wr_en_wb, 0);
    check("s3_busy_clear", vreg_busy_wb, 0);

    // Overlapping writes to v5.
    set_vec(5'd5, 128'h51, '1);
    step();
    set_vec(5'd5, 128'h52, 16'h00FF);
    check("s4_busy_a", vreg_busy_wb[5], 1);
    step();
    valid_exe = 0;
    check("s4_busy_b", vreg_busy_wb[5], 1);
    check("s4_data2", vrf_wr_data_wb, 128'h52);
    check("s4_be2", vrf_wr_be_wb, 16'h00FF);
    step();
    check("s4_busy_off", vreg_busy_wb[5], 0);

    // Fully masked beat retires without a write, even with the port stalled.
    vrf_wr_ready_wb = 0;
    set_vec(5'd9, 128'h99, '0);
    step();
    valid_exe = 0;
    check("s5_no_en", vrf_wr_en_wb, 0);
    check("s5_busy9", vreg_busy_wb[9], 1);
    step();
    check("s5_busy9_off", vreg_busy_wb[9], 0);
    check("s5_ready", ready_exe, 1);

    // Reset with two entries pending.
    set_vec(5'd1, 128'h1, '1);
    step();
    set_vec(5'd2, 128'h2, '1);
    step();
    valid_exe = 0;
    check("s6_full", ready_exe, 0);
    rst = 1;
    step();
    rst = 0;
    check("s6_ready", ready_exe, 1);
    check("s6_en", vrf_wr_en_wb, 0);
    check("s6_data", vrf_wr_data_wb, 0);
    check("s6_int", int_wr_valid_wb, 0);
    check("s6_busy", vreg_busy_wb, 0);
    vrf_wr_ready_wb = 1; int_wr_ready_wb = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s6_no_stale", vrf_wr_en_wb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
